// File: rtl/reset_sequencer.sv
// reset_sequencer: board-level reset generator.
//
// Holds NUM_CHANNELS active-high resets asserted after power-on, PLL unlock or a debounced key
// press, then releases them in index order. The first channel is released HOLD_TICKS ticks after
// the last fault clears. Each further channel follows STAGGER_TICKS ticks later. A tick is one
// clock in every 2^PRESCALE_BITS.
//
// Ports:
//   clock         system clock (PLL output)
//   reset         asynchronous active-high reset
//   pll_locked_i  PLL lock, asynchronous, synchronised internally
//   key_i         raw push-button, synchronised then debounced
//   wdt_kick_i    single-clock watchdog kick, synchronous to clock
//   rst_o         per-channel active-high reset, driven straight from flops
//   ready_o       high once every channel is released
//   cause_o       last reset cause: 0 POR, 1 PLL, 2 KEY, 3 WDT
//
// Optional feature: define RESET_SEQUENCER_WDT_EN to add a tick-counted watchdog that runs in
// RUN only. Without the macro, wdt_kick_i is ignored and cause 3 never occurs.

`timescale 1ns/1ps

module reset_sequencer #(
  parameter int unsigned NUM_CHANNELS   = 2,
  parameter int unsigned PRESCALE_BITS  = 8,
  parameter int unsigned HOLD_TICKS     = 16,
  parameter int unsigned STAGGER_TICKS  = 4,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned KEY_ACTIVE_LOW = 1,
  parameter int unsigned WDT_TICKS      = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    pll_locked_i,
  input  logic                    key_i,
  input  logic                    wdt_kick_i,
  output logic [NUM_CHANNELS-1:0] rst_o,
  output logic                    ready_o,
  output logic [1:0]              cause_o
);

  // Zero-length hold or stagger behaves as one tick.
  localparam int unsigned HoldMax = (HOLD_TICKS == 0) ? 1 : HOLD_TICKS;
  localparam int unsigned StagMax = (STAGGER_TICKS == 0) ? 1 : STAGGER_TICKS;
  localparam int unsigned DebMax  = (DEBOUNCE_TICKS == 0) ? 1 : DEBOUNCE_TICKS;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);
  localparam int unsigned StagW   = $clog2(StagMax + 1);
  localparam int unsigned DebW    = $clog2(DebMax + 1);
  localparam int unsigned IdxW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldMax - 1);
  localparam logic [StagW-1:0] StagLast = StagW'(StagMax - 1);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DebMax - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_CHANNELS - 1);

  localparam logic [1:0] CausePll = 2'd1;
  localparam logic [1:0] CauseKey = 2'd2;

  typedef enum logic [1:0] {StHold, StRelease, StRun} state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_BITS-1:0]  presc_q, presc_d;
  logic                      pll_s1_q, pll_s1_d, pll_s2_q, pll_s2_d;
  logic                      key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [DebW-1:0]           deb_q, deb_d;
  logic                      key_stable_q, key_stable_d;
  logic [HoldW-1:0]          hold_q, hold_d;
  logic [StagW-1:0]          stag_q, stag_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [NUM_CHANNELS-1:0]   rst_q, rst_d;
  logic                      ready_q, ready_d;
  logic [1:0]                cause_q, cause_d;

  logic       tick;
  logic       key_pressed_raw;
  logic       key_evt;
  logic       wdt_expire;
  logic       fault;
  logic [1:0] cause_sel;

  // Prescaler, synchronisers and debouncer.
  always_comb begin
    presc_d         = presc_q + 1'b1;
    tick            = &presc_q;
    pll_s1_d        = pll_locked_i;
    pll_s2_d        = pll_s1_q;
    key_s1_d        = key_i;
    key_s2_d        = key_s1_q;
    key_pressed_raw = (KEY_ACTIVE_LOW != 0) ? ~key_s2_q : key_s2_q;
    deb_d           = deb_q;
    key_stable_d    = key_stable_q;
    if (tick) begin
      if (key_pressed_raw != key_stable_q) begin
        if (deb_q == DebLast) begin
          key_stable_d = ~key_stable_q;
          deb_d        = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end else begin
        deb_d = '0;
      end
    end
  end

  assign key_evt = key_stable_q;
  assign fault   = ~pll_s2_q | key_evt | wdt_expire;

  // Priority PLL > KEY > WDT when several faults land together.
  always_comb begin
    cause_sel = CauseKey;
    if (!pll_s2_q) begin
      cause_sel = CausePll;
`ifdef RESET_SEQUENCER_WDT_EN
    end else if (!key_evt) begin
      cause_sel = 2'd3;
`endif
    end
  end

  // Sequencing FSM.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stag_d  = stag_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    cause_d = cause_q;
    unique case (state_q)
      StHold: begin
        rst_d   = '1;
        ready_d = 1'b0;
        // A lingering fault only keeps the counter at zero and never rewrites the cause.
        if (fault) begin
          hold_d = '0;
        end else if (tick) begin
          if (hold_q == HoldLast) begin
            hold_d   = '0;
            rst_d[0] = 1'b0;
            if (NUM_CHANNELS == 1) begin
              state_d = StRun;
              ready_d = 1'b1;
            end else begin
              state_d = StRelease;
              idx_d   = IdxW'(1);
              stag_d  = '0;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      StRelease: begin
        if (tick) begin
          if (stag_q == StagLast) begin
            stag_d       = '0;
            rst_d[idx_q] = 1'b0;
            if (idx_q == IdxLast) begin
              state_d = StRun;
              ready_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            stag_d = stag_q + 1'b1;
          end
        end
      end
      StRun: begin
        rst_d   = '0;
        ready_d = 1'b1;
      end
      default: state_d = StHold;
    endcase
    // Fault-driven HOLD entry overrides any progress made this cycle.
    if (fault && (state_q != StHold)) begin
      state_d = StHold;
      rst_d   = '1;
      ready_d = 1'b0;
      hold_d  = '0;
      stag_d  = '0;
      idx_d   = '0;
      cause_d = cause_sel;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StHold;
      presc_q      <= '0;
      pll_s1_q     <= 1'b0;
      pll_s2_q     <= 1'b0;
      key_s1_q     <= 1'b0;
      key_s2_q     <= 1'b0;
      deb_q        <= '0;
      key_stable_q <= 1'b0;
      hold_q       <= '0;
      stag_q       <= '0;
      idx_q        <= '0;
      rst_q        <= '1;
      ready_q      <= 1'b0;
      cause_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      pll_s1_q     <= pll_s1_d;
      pll_s2_q     <= pll_s2_d;
      key_s1_q     <= key_s1_d;
      key_s2_q     <= key_s2_d;
      deb_q        <= deb_d;
      key_stable_q <= key_stable_d;
      hold_q       <= hold_d;
      stag_q       <= stag_d;
      idx_q        <= idx_d;
      rst_q        <= rst_d;
      ready_q      <= ready_d;
      cause_q      <= cause_d;
    end
  end

`ifdef RESET_SEQUENCER_WDT_EN
  localparam int unsigned      WdtMax  = (WDT_TICKS == 0) ? 1 : WDT_TICKS;
  localparam int unsigned      WdtW    = $clog2(WdtMax + 1);
  localparam logic [WdtW-1:0]  WdtLast = WdtW'(WdtMax);

  logic [WdtW-1:0] wdt_q, wdt_d;

  // Kick wins over a coincident tick; the count is dropped whenever RUN is not held.
  always_comb begin
    wdt_d = wdt_q;
    if ((state_q != StRun) || (state_d != StRun)) begin
      wdt_d = '0;
    end else if (wdt_kick_i) begin
      wdt_d = '0;
    end else if (tick && (wdt_q != WdtLast)) begin
      wdt_d = wdt_q + 1'b1;
    end
  end

  assign wdt_expire = (state_q == StRun) && (wdt_q == WdtLast);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic [1:0] unused_wdt;
  assign unused_wdt = {wdt_kick_i, WDT_TICKS[0]};
  assign wdt_expire = 1'b0;
`endif

  assign rst_o   = rst_q;
  assign ready_o = ready_q;
  assign cause_o = cause_q;

endmodule
